// File: rtl/svc_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised input, mid-bit sampling FSM and a
// first-word-fall-through output FIFO with framing-error and overrun pulses.
module svc_uart_rx #(
  parameter int CLOCK_FREQ = 25_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       urx_in,
  output logic       urx_valid,
  output logic [7:0] urx_data,
  input  logic       urx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int CPB  = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] C_CPB_M1  = CW'(CPB - 1);

  generate
    if (CPB < 4) begin : g_bad_cpb
      $error("svc_uart_rx: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("svc_uart_rx: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  // IDLE encodes as 0 so dbg_state reads 0 whenever the receiver is quiet.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_t;

  logic          r_sync1;
  logic          r_rx_s;
  state_t        r_state;
  logic          r_armed;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_frame_err;
  logic          r_overrun;
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [7:0]    r_mem [FIFO_DEPTH];

  logic w_stop_hit;
  logic w_push;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_wr_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= urx_in;
      r_rx_s  <= r_sync1;
    end
  end

  assign w_stop_hit = (r_state == S_STOP) && (r_cnt == C_CPB_M1);
  assign w_push     = w_stop_hit && r_rx_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_armed     <= 1'b0;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        // armed keeps a line held low (break or bad stop) from restarting a frame.
        S_IDLE: begin
          if (r_rx_s) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_armed <= 1'b0;
          end
        end
        S_START: begin
          if (r_cnt == C_HALF_M1) begin
            if (r_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_DATA;
              r_cnt     <= '0;
              r_bit_idx <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == C_CPB_M1) begin
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_cnt     <= '0;
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == C_CPB_M1) begin
            r_state     <= S_IDLE;
            r_frame_err <= !r_rx_s;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Valid/ready: a byte moves when urx_valid && urx_ready at a clock edge;
  // urx_valid depends only on registered pointers, never on urx_ready.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && urx_ready;
  assign w_wr_en = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst_n && w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push && !w_wr_en;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign urx_valid = !w_empty;
  assign urx_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_svc_uart_rx.sv
// Bench for svc_uart_rx: directed scenarios plus random frames, checked each
// cycle against a byte-queue model of the receive FIFO.
module tb_svc_uart_rx;

  localparam int CPB   = 25_000_000 / 115200;
  localparam int HALF  = CPB / 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       urx_in = 1'b1;
  logic       urx_ready = 1'b0;
  logic       urx_valid;
  logic [7:0] urx_data;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [1:0] dbg_state;

  svc_uart_rx #(.CLOCK_FREQ(25_000_000), .BAUD_RATE(115200), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .urx_in(urx_in),
    .urx_valid(urx_valid), .urx_data(urx_data), .urx_ready(urx_ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [7:0] exp_q[$];
  bit         ev_pend = 1'b0;
  int         ev_cyc;
  logic [7:0] ev_byte;
  bit         ev_stop;
  bit         exp_fe = 1'b0;
  bit         exp_ov = 1'b0;
  int         fe_seen = 0;
  int         ov_seen = 0;

  // A frame whose start goes low in cycle T0 has its stop bit judged in cycle
  // T0+2+HALF+9*CPB; the byte is then visible from the following cycle.
  always @(negedge clk) begin
    bit pop;
    bit full_before;
    if (!rst_n) begin
      exp_q.delete();
      ev_pend = 1'b0;
      exp_fe  = 1'b0;
      exp_ov  = 1'b0;
    end else begin
      chk("valid", urx_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("data", urx_data, exp_q[0]);
      chk("frame_err", frame_err, exp_fe);
      chk("overrun", overrun, exp_ov);
      if (frame_err === 1'b1) fe_seen++;
      if (overrun === 1'b1) ov_seen++;
      full_before = (exp_q.size() == DEPTH);
      pop = (exp_q.size() != 0) && urx_ready;
      if (pop) void'(exp_q.pop_front());
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      if (ev_pend && cyc == ev_cyc) begin
        ev_pend = 1'b0;
        if (!ev_stop) exp_fe = 1'b1;
        else if (!full_before || pop) exp_q.push_back(ev_byte);
        else exp_ov = 1'b1;
      end
    end
  end

  // ---------------- driver tasks (called #1 after a posedge) ----------------
  task automatic send_frame(input logic [7:0] b, input bit stop, input int len);
    ev_cyc  = cyc + 2 + HALF + 9 * CPB;
    ev_byte = b;
    ev_stop = stop;
    ev_pend = 1'b1;
    urx_in = 1'b0;
    repeat (len) @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      urx_in = b[k];
      repeat (len) @(posedge clk);
      #1;
    end
    urx_in = stop;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    urx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  bit rr_en = 1'b0;
  always @(posedge clk) begin
    if (rr_en) begin
      #1;
      urx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  int fe0, ov0, bc;
  logic [7:0] rb;

  // ---------------- directed + random sequence ----------------
  initial begin
    fork
      begin : main_seq
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", urx_valid, 0);
        chk("rst_fe", frame_err, 0);
        chk("rst_ov", overrun, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", dbg_state, 0);
        @(posedge clk);
        #1;
        idle(10);

        // single byte, exact valid pulse timing
        urx_ready = 1'b1;
        fe0 = fe_seen; ov0 = ov_seen;
        fork
          send_frame(8'hA5, 1'b1, CPB);
          begin
            repeat (2 + 108 + 9 * 217) @(posedge clk);
            @(negedge clk);
            chk("a5_before", urx_valid, 0);
            @(negedge clk);
            chk("a5_valid", urx_valid, 1);
            chk("a5_data", urx_data, 8'hA5);
            @(negedge clk);
            chk("a5_after", urx_valid, 0);
          end
        join
        idle(20);
        chk("a5_no_fe", fe_seen - fe0, 0);
        chk("a5_no_ov", ov_seen - ov0, 0);

        // start-bit glitch of 50 cycles
        bc = 0;
        urx_in = 1'b0;
        for (int i = 0; i < 300; i++) begin
          @(negedge clk);
          if (busy) bc++;
          @(posedge clk);
          #1;
          if (i == 49) urx_in = 1'b1;
        end
        chk("glitch_busy_cycles", bc, HALF);
        chk("glitch_idle", busy, 0);

        // framing error, line held low, then a good byte
        fe0 = fe_seen;
        send_frame(8'h3C, 1'b0, CPB);
        for (int i = 0; i < 3; i++) begin
          repeat (CPB - 1) @(posedge clk);
          @(negedge clk);
          chk("held_low_idle", busy, 0);
          @(posedge clk);
          #1;
        end
        chk("fe_count", fe_seen - fe0, 1);
        idle(50);
        send_frame(8'h55, 1'b1, CPB);
        idle(20);

        // overrun with consumer stalled
        urx_ready = 1'b0;
        ov0 = ov_seen;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, CPB);
        idle(20);
        chk("ov_count", ov_seen - ov0, 1);
        chk("ov_full_valid", urx_valid, 1);
        urx_ready = 1'b1;
        idle(10);
        chk("ov_drained", urx_valid, 0);

        // full FIFO with pop in the exact push cycle
        urx_ready = 1'b0;
        ov0 = ov_seen;
        for (int i = 1; i <= 4; i++) send_frame(8'h10 + 8'(i), 1'b1, CPB);
        fork
          send_frame(8'h15, 1'b1, CPB);
          begin
            repeat (2 + HALF + 9 * CPB) @(posedge clk);
            #1;
            urx_ready = 1'b1;
            @(posedge clk);
            #1;
            urx_ready = 1'b0;
          end
        join
        idle(10);
        chk("simpop_no_ov", ov_seen - ov0, 0);
        urx_ready = 1'b1;
        idle(10);
        chk("simpop_drained", urx_valid, 0);

        // reset during data bit 4 with two bytes queued
        urx_ready = 1'b0;
        send_frame(8'h11, 1'b1, CPB);
        send_frame(8'h22, 1'b1, CPB);
        fork
          send_frame(8'hF0, 1'b1, CPB);
          begin
            repeat (5 * CPB + CPB / 2) @(posedge clk);
            #1;
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(negedge clk);
            chk("mid_rst_valid", urx_valid, 0);
            chk("mid_rst_fe", frame_err, 0);
            chk("mid_rst_ov", overrun, 0);
            chk("mid_rst_busy", busy, 0);
          end
        join
        idle(20);
        chk("mid_rst_no_byte", urx_valid, 0);
        urx_ready = 1'b1;
        send_frame(8'h99, 1'b1, CPB);
        idle(20);

        // random bytes, bit lengths within +-4 cycles, random consumer
        rr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
          rb = 8'($urandom_range(0, 255));
          send_frame(rb, ($urandom_range(0, 5) != 0), $urandom_range(CPB - 4, CPB + 4));
          idle($urandom_range(2, 20));
        end
        rr_en = 1'b0;
        urx_ready = 1'b1;
        idle(20);
        chk("rand_drained", urx_valid, 0);
      end
      wait (fails >= 20);
    join_any
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/svc_uart_rx.md
# svc_uart_rx

Synthesizable 8N1 UART receiver that decodes the serial stream driven by the SoC's `uart_tx` pin and delivers bytes on a valid/ready interface through a small first-word-fall-through FIFO. It sits opposite the SoC UART transmitter:

- in simulation benches, as the console decoder and loopback checker;
- on hardware, as the host-to-SoC receive path.

Framing errors, start-bit glitches and FIFO overruns are detected and reported as single-cycle pulses.

## Interface

Parameters:

- `CLOCK_FREQ`, 25_000_000 — clk frequency in Hz.
- `BAUD_RATE`, 115200 — line rate in bit/s.
- `FIFO_DEPTH`, 4 — output FIFO entries; power of two, at least 2.

Ports:

- `clk`  in  1  clock.
- `rst_n`  in  1  reset: synchronous, active-low.
- `urx_in`  in  1  serial line, asynchronous to clk, idle high.
- `urx_valid`  out  1  FIFO non-empty; `urx_data` is valid.
- `urx_data`  out  8  FIFO head byte.
- `urx_ready`  in  1  consumer accepts head when `urx_valid && urx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: byte dropped, FIFO full.
- `busy`  out  1  high when the receiver state is not IDLE.

## Operation

Derived constants:

- `CPB = CLOCK_FREQ / BAUD_RATE` (integer, truncating); 217 at defaults.
- `HALF = CPB / 2`; 108 at defaults.
- Bit counter width is `$clog2(CPB)`. Elaboration fails if `CPB < 4`.

Input conditioning:

- `urx_in` passes through a 2-flop synchronizer, giving `rx_s`.
- The synchronizer flops reset to 1.

State machine: IDLE, START, DATA, STOP.

- **IDLE**
  - Internal `armed` sets when `rx_s == 1`.
  - When `armed && rx_s == 0`: go to START, `cnt = 0`, clear `armed`.
  - `armed` prevents a held-low line (break, or a framing error with the line low) from retriggering.
- **START**
  - `cnt` increments each cycle.
  - At `cnt == HALF-1`, sample `rx_s`.
  - If the sample is 1: glitch; return to IDLE with no pulse.
  - If the sample is 0: go to DATA with `cnt = 0`, `bit_idx = 0`.
- **DATA**
  - At `cnt == CPB-1`, shift `rx_s` into the shift register at bit 7 (shift right, LSB first), set `cnt = 0`, increment `bit_idx`.
  - After the 8th sample (`bit_idx == 7`), go to STOP.
- **STOP**
  - At `cnt == CPB-1`, sample `rx_s`, then go to IDLE.
  - If the sample is 1: push the shift register into the FIFO.
  - If the sample is 0: pulse `frame_err` and discard the byte.

FIFO:

- Read and write pointers are `$clog2(FIFO_DEPTH)+1` bits with wrap bit. Full = pointers equal except MSB; empty = pointers equal.
- `urx_valid = !empty`; `urx_data = mem[rd_ptr]` (first-word fall-through).
- A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
- Otherwise the byte is dropped and `overrun` pulses. FIFO contents are unchanged.
- Simultaneous push and pop on a non-empty FIFO keeps the occupancy unchanged.

Reset values (synchronous, while `rst_n == 0`):

- State IDLE; `armed` 0.
- `cnt`, `bit_idx`, shift register, and both pointers 0.
- `urx_valid` 0, `urx_data` undefined, `frame_err` 0, `overrun` 0, `busy` 0.

Reset mid-frame discards the partial byte and all FIFO contents. After reset, reception requires the line to be seen high (`armed`) before the next start edge.

## Timing

- Start edge on `urx_in` at cycle T0 is seen as `rx_s == 0` at T0+2; START is entered at T0+3.
- Start bit sample at T0+2+HALF.
- Data bit k (k = 0..7) sampled at T0+2+HALF+(k+1)·CPB.
- Stop bit sampled at T0+2+HALF+9·CPB. The FIFO push happens at that clock edge; `urx_valid` rises the following cycle.
- The `frame_err` or `overrun` pulse is asserted for exactly the one cycle after the stop-sample edge.
- Back-to-back frames: the next start edge is accepted any time after IDLE is re-entered, provided `rx_s` was seen high for ≥1 cycle.
- The receiver tolerates ±4% baud mismatch with mid-bit sampling.
- Pop: head advances at the edge where `urx_valid && urx_ready`. The new head is visible the next cycle. There is no combinational path from `urx_ready` to `urx_valid`.

## Test plan

- **Single byte:** drive 0xA5 at 115200 baud (CPB 217) with `urx_ready = 1`.
  - `urx_valid` pulses for one cycle with `urx_data == 0xA5` at T0+2+108+9·217+1.
  - `frame_err` and `overrun` stay 0.
- **Glitch:** pull `urx_in` low for 50 cycles, then high.
  - No `urx_valid`, no `frame_err`, `busy` high for ≤110 cycles, then IDLE.
- **Framing error:** send 0x3C with the stop bit low, hold low for 3 bit times, then idle high and send 0x55.
  - One `frame_err` pulse, no push.
  - No retrigger while the line is held low.
  - 0x55 is then received correctly.
- **Overrun:** send 0x01..0x05 back-to-back with `urx_ready = 0` (FIFO_DEPTH 4).
  - `overrun` pulses once, after 0x05.
  - Raising `urx_ready` then yields 0x01, 0x02, 0x03, 0x04 in order, then `urx_valid` 0.
- **Full with simultaneous pop:** with FIFO full, assert `urx_ready` in the exact cycle of the 5th push.
  - No overrun; the byte is queued behind the remaining three.
- **Reset mid-frame:** assert `rst_n = 0` for 1 cycle during data bit 4 of 0xF0, with the FIFO holding 2 bytes.
  - All outputs return to reset values and the FIFO is empty.
  - The remainder of the frame does not produce a byte.
  - A subsequent 0x99 is received correctly.
